// File: rtl/formacao_inimigos.sv
// ============================================================================
// formacao_inimigos : LINHAS x COLUNAS invader block marching on a tick enable
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module formacao_inimigos #(
  parameter int LINHAS      = 3,
  parameter int COLUNAS     = 8,
  parameter int LARG        = 33,
  parameter int ALT         = 24,
  parameter int ESP         = 12,
  parameter int PASSO_X     = 20,
  parameter int PASSO_Y     = 20,
  parameter int TELA_L      = 640,
  parameter int LIMITE_Y    = 440,
  parameter int DIV_INICIAL = 25000000,
  parameter int DIV_DEC     = 1000000,
  parameter int DIV_MIN     = 2500000
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        pausa,
  input  logic                        reiniciarJogo,
  input  logic [9:0]                  xi,
  input  logic [9:0]                  yi,
  input  logic [9:0]                  bola_x,
  input  logic [9:0]                  bola_y,
  input  logic                        bola_valida,
  output logic [9:0]                  x,
  output logic [9:0]                  y,
  output logic [LINHAS*COLUNAS-1:0]   vivos,
  output logic                        acerto,
  output logic [5:0]                  acerto_idx,
  output logic [6:0]                  restantes,
  output logic                        invadiu,
  output logic                        limpo
);

  localparam int N  = LINHAS * COLUNAS;
  localparam int PX = LARG + ESP;
  localparam int PY = ALT + ESP;

  localparam logic [31:0] C_DIV_INI = 32'(DIV_INICIAL);
  localparam logic [31:0] C_DIV_DEC = 32'(DIV_DEC);
  localparam logic [31:0] C_DIV_MIN = 32'(DIV_MIN);
  localparam logic [6:0]  C_N       = 7'(N);

  logic [9:0]   x_q, x_d, y_q, y_d;
  logic [N-1:0] vivos_q, vivos_d;
  logic         dir_esq_q, dir_esq_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         acerto_q, acerto_d;
  logic [5:0]   idx_q, idx_d;
  logic [6:0]   restantes_q, restantes_d;
  logic         invadiu_q, invadiu_d;
  logic         limpo_q, limpo_d;

  logic [N-1:0]       w_hit, w_inv, w_kill;
  logic               w_hit_any;
  logic [5:0]         w_hit_idx;
  logic [COLUNAS-1:0] w_col_viva;
  logic [5:0]         w_cmin, w_cmax;
  logic               w_cfound;
  logic [11:0]        w_esq, w_dir;
  logic [31:0]        w_dec, w_periodo;
  logic               w_tick, w_frozen;

  assign w_frozen = invadiu_q | limpo_q;

  // Per-enemy box: strict bullet containment and invasion-line test.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_inimigo
      localparam int R = gi / COLUNAS;
      localparam int C = gi % COLUNAS;
      logic [10:0] w_ex, w_ey;
      assign w_ex = {1'b0, x_q} + 11'(C * PX);
      assign w_ey = {1'b0, y_q} + 11'(R * PY);
      assign w_hit[gi] = bola_valida && vivos_q[gi]
                       && ({1'b0, bola_x} > w_ex) && ({1'b0, bola_x} < w_ex + 11'(LARG))
                       && ({1'b0, bola_y} > w_ey) && ({1'b0, bola_y} < w_ey + 11'(ALT));
      assign w_inv[gi] = vivos_q[gi] && ({1'b0, w_ey} + 12'(ALT) >= 12'(LIMITE_Y));
    end
  endgenerate

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = 6'd0;
    w_kill    = '0;
    for (int i = 0; i < N; i++) begin
      if (w_hit[i] && !w_hit_any) begin
        w_hit_any = 1'b1;
        w_hit_idx = 6'(i);
        w_kill[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_col_viva = '0;
    for (int r = 0; r < LINHAS; r++) begin
      for (int c = 0; c < COLUNAS; c++) begin
        if (vivos_q[r*COLUNAS + c]) w_col_viva[c] = 1'b1;
      end
    end
  end

  always_comb begin
    w_cmin   = 6'd0;
    w_cmax   = 6'd0;
    w_cfound = 1'b0;
    for (int c = 0; c < COLUNAS; c++) begin
      if (w_col_viva[c]) begin
        if (!w_cfound) w_cmin = 6'(c);
        w_cfound = 1'b1;
        w_cmax   = 6'(c);
      end
    end
  end

  assign w_esq = {2'b00, x_q} + 12'(32'(w_cmin) * PX);
  assign w_dir = {2'b00, x_q} + 12'(32'(w_cmax) * PX) + 12'(LARG);

  // Period shrinks with each kill, clamped at the floor.
  assign w_dec     = 32'(C_N - restantes_q) * C_DIV_DEC;
  assign w_periodo = (w_dec + C_DIV_MIN >= C_DIV_INI) ? C_DIV_MIN : (C_DIV_INI - w_dec);
  assign w_tick    = !pausa && (cnt_q >= w_periodo - 32'd1);

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    dir_esq_d   = dir_esq_q;
    vivos_d     = vivos_q;
    acerto_d    = 1'b0;
    idx_d       = idx_q;
    restantes_d = restantes_q;
    cnt_d       = cnt_q;

    if (!pausa) cnt_d = w_tick ? 32'd0 : cnt_q + 32'd1;

    if (!w_frozen && w_tick) begin
      if (!dir_esq_q) begin
        if (w_dir + 12'(PASSO_X) > 12'(TELA_L)) begin
          y_d       = y_q + 10'(PASSO_Y);
          dir_esq_d = 1'b1;
        end else begin
          x_d = x_q + 10'(PASSO_X);
        end
      end else begin
        if (w_esq < 12'(PASSO_X)) begin
          y_d       = y_q + 10'(PASSO_Y);
          dir_esq_d = 1'b0;
        end else begin
          x_d = x_q - 10'(PASSO_X);
        end
      end
    end

    if (!pausa && !w_frozen && w_hit_any) begin
      vivos_d     = vivos_q & ~w_kill;
      acerto_d    = 1'b1;
      idx_d       = w_hit_idx;
      restantes_d = restantes_q - 7'd1;
    end

    invadiu_d = invadiu_q | (|w_inv);
    limpo_d   = limpo_q | (restantes_q == 7'd0);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      x_q         <= xi;
      y_q         <= yi;
      vivos_q     <= '1;
      dir_esq_q   <= 1'b0;
      cnt_q       <= 32'd0;
      acerto_q    <= 1'b0;
      idx_q       <= 6'd0;
      restantes_q <= C_N;
      invadiu_q   <= 1'b0;
      limpo_q     <= 1'b0;
    end else if (reiniciarJogo) begin
      x_q         <= xi;
      y_q         <= yi;
      vivos_q     <= '1;
      dir_esq_q   <= 1'b0;
      cnt_q       <= 32'd0;
      acerto_q    <= 1'b0;
      idx_q       <= 6'd0;
      restantes_q <= C_N;
      invadiu_q   <= 1'b0;
      limpo_q     <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vivos_q     <= vivos_d;
      dir_esq_q   <= dir_esq_d;
      cnt_q       <= cnt_d;
      acerto_q    <= acerto_d;
      idx_q       <= idx_d;
      restantes_q <= restantes_d;
      invadiu_q   <= invadiu_d;
      limpo_q     <= limpo_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign vivos      = vivos_q;
  assign acerto     = acerto_q;
  assign acerto_idx = idx_q;
  assign restantes  = restantes_q;
  assign invadiu    = invadiu_q;
  assign limpo      = limpo_q;

endmodule

`default_nettype wire
